// File: rtl/rou_buf_alloc_pkg.sv
// Shared roubus buffer-pool definitions: default sizing, request/grant
// bundles and the per-cycle grant limit.
package rou_buf_alloc_pkg;

  localparam int BUFS_DEF    = 8;
  localparam int WBUFS_DEF   = 6;
  localparam int LOWMARK_DEF = 2;

  // Most buffers that can be granted in a single cycle.
  localparam logic [1:0] NUM_MAX = 2'd3;

  // Upstream allocation request.
  typedef struct packed {
    logic       vld;
    logic [1:0] num;
  } alloc_req_t;

  // Grant returned to the requester (default index width).
  typedef struct packed {
    logic                 vld;
    logic [1:0]           num;
    logic [WBUFS_DEF-1:0] idx0;
    logic [WBUFS_DEF-1:0] idx1;
    logic [WBUFS_DEF-1:0] idx2;
  } grant_t;

endpackage

// File: rtl/rou_availables.sv
// Free-index search: returns the three lowest clear bit positions of the
// occupancy bitmap. Positions past the last free buffer read as 0.
module rou_availables
  import rou_buf_alloc_pkg::*;
#(
  parameter int BUFS  = BUFS_DEF,
  parameter int WBUFS = WBUFS_DEF
) (
  input  logic [BUFS-1:0]  occupied,
  output logic [WBUFS-1:0] free0,
  output logic [WBUFS-1:0] free1,
  output logic [WBUFS-1:0] free2
);

  logic [1:0] found;

  // Priority scan from bit 0 upward, capturing the first three free slots.
  always_comb begin
    free0 = '0;
    free1 = '0;
    free2 = '0;
    found = 2'd0;
    for (int i = 0; i < BUFS; i++) begin
      if (!occupied[i]) begin
        if (found == 2'd0)      free0 = WBUFS'(i);
        else if (found == 2'd1) free1 = WBUFS'(i);
        else if (found == 2'd2) free2 = WBUFS'(i);
        if (found != 2'd3) found = found + 2'd1;
      end
    end
  end

endmodule

// File: rtl/rou_buf_alloc.sv
// Buffer allocator for the roubus buffer pool. Owns the occupancy bitmap and
// an independent free counter, grants up to three buffers per cycle and
// accepts one release per cycle.
//
// Handshake: a request is taken on a rising edge when alloc_vld, alloc_rdy
// and a nonzero alloc_num are all high in the preceding cycle; the requester
// holds alloc_vld/alloc_num stable until then. alloc_rdy only says whether
// enough buffers are free right now (a release in the same cycle does not
// count). The grant appears as a one-cycle gnt_vld pulse on the next cycle.
module rou_buf_alloc
  import rou_buf_alloc_pkg::*;
#(
  parameter int BUFS    = BUFS_DEF,
  parameter int WBUFS   = WBUFS_DEF,
  parameter int LOWMARK = LOWMARK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_vld,
  input  logic [1:0]       alloc_num,
  output logic             alloc_rdy,
  output logic             gnt_vld,
  output logic [1:0]       gnt_num,
  output logic [WBUFS-1:0] gnt_idx0,
  output logic [WBUFS-1:0] gnt_idx1,
  output logic [WBUFS-1:0] gnt_idx2,
  input  logic             rel_vld,
  input  logic [WBUFS-1:0] rel_idx,
  output logic [BUFS-1:0]  occupied,
  output logic [WBUFS-1:0] free_count,
  output logic             low_free,
  output logic             err_rel
);

  alloc_req_t       req;
  logic [WBUFS-1:0] num_ext;
  logic             accept;
  logic [WBUFS-1:0] free0;
  logic [WBUFS-1:0] free1;
  logic [WBUFS-1:0] free2;
  logic             rel_in_range;
  logic [BUFS-1:0]  rel_mask;
  logic             rel_hit;
  logic             rel_bad;
  logic [BUFS-1:0]  alloc_mask;
  logic [BUFS-1:0]  occ_next;
  logic [WBUFS-1:0] count_next;

  assign req     = '{vld: alloc_vld, num: alloc_num};
  assign num_ext = WBUFS'(req.num);

  // No partial grants: ready only when the whole request fits.
  assign alloc_rdy = (num_ext <= free_count);
  assign accept    = req.vld & alloc_rdy & (req.num != 2'd0);

  // Free slots are searched on the registered bitmap, so a buffer released
  // this cycle becomes a candidate only from the next cycle.
  rou_availables #(
    .BUFS  (BUFS),
    .WBUFS (WBUFS)
  ) u_availables (
    .occupied (occupied),
    .free0    (free0),
    .free1    (free1),
    .free2    (free2)
  );

  // A release only counts if it names an in-range, currently occupied slot.
  assign rel_in_range = (rel_idx < WBUFS'(BUFS));
  assign rel_mask     = rel_in_range ? (BUFS'(1) << rel_idx) : '0;
  assign rel_hit      = rel_vld & (|(occupied & rel_mask));
  assign rel_bad      = rel_vld & ~rel_hit;

  // Next bitmap and counter; allocated slots are free, so they never collide
  // with the slot being released.
  always_comb begin
    alloc_mask = '0;
    if (accept) begin
      alloc_mask = alloc_mask | (BUFS'(1) << free0);
      if (req.num >= 2'd2)    alloc_mask = alloc_mask | (BUFS'(1) << free1);
      if (req.num == NUM_MAX) alloc_mask = alloc_mask | (BUFS'(1) << free2);
    end
    occ_next   = (occupied | alloc_mask) & ~(rel_hit ? rel_mask : '0);
    count_next = free_count - (accept ? num_ext : '0) + (rel_hit ? WBUFS'(1) : '0);
  end

  // Pool state: bitmap, free counter, low-water flag and sticky release error.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupied   <= '0;
      free_count <= WBUFS'(BUFS);
      low_free   <= (BUFS <= LOWMARK);
      err_rel    <= 1'b0;
    end else begin
      occupied   <= occ_next;
      free_count <= count_next;
      low_free   <= (count_next <= WBUFS'(LOWMARK));
      if (rel_bad) err_rel <= 1'b1;
    end
  end

  // Grant register: pulse on accept, unused index fields keep old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_vld  <= 1'b0;
      gnt_num  <= 2'd0;
      gnt_idx0 <= '0;
      gnt_idx1 <= '0;
      gnt_idx2 <= '0;
    end else begin
      gnt_vld <= accept;
      if (accept) begin
        gnt_num  <= req.num;
        gnt_idx0 <= free0;
        if (req.num >= 2'd2)    gnt_idx1 <= free1;
        if (req.num == NUM_MAX) gnt_idx2 <= free2;
      end
    end
  end

  // The counter must always agree with the bitmap population.
  a_free_count : assert property (@(posedge clk) disable iff (rst)
    free_count == WBUFS'(BUFS - $countones(occupied)));

endmodule

// File: tb/tb_rou_buf_alloc.sv
// Bench for rou_buf_alloc: directed scenarios plus a randomized soak against
// an array-based pool model.
module tb_rou_buf_alloc;

  localparam int BUFS  = 8;
  localparam int WBUFS = 6;

  // ---- clock / reset / DUT ----
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             alloc_vld = 1'b0;
  logic [1:0]       alloc_num = 2'd0;
  logic             alloc_rdy;
  logic             gnt_vld;
  logic [1:0]       gnt_num;
  logic [WBUFS-1:0] gnt_idx0, gnt_idx1, gnt_idx2;
  logic             rel_vld = 1'b0;
  logic [WBUFS-1:0] rel_idx = '0;
  logic [BUFS-1:0]  occupied;
  logic [WBUFS-1:0] free_count;
  logic             low_free;
  logic             err_rel;

  always #5 clk = ~clk;

  rou_buf_alloc #(.BUFS(BUFS), .WBUFS(WBUFS), .LOWMARK(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_vld  (alloc_vld),
    .alloc_num  (alloc_num),
    .alloc_rdy  (alloc_rdy),
    .gnt_vld    (gnt_vld),
    .gnt_num    (gnt_num),
    .gnt_idx0   (gnt_idx0),
    .gnt_idx1   (gnt_idx1),
    .gnt_idx2   (gnt_idx2),
    .rel_vld    (rel_vld),
    .rel_idx    (rel_idx),
    .occupied   (occupied),
    .free_count (free_count),
    .low_free   (low_free),
    .err_rel    (err_rel)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---- reference model: pool as an array of in-use flags ----
  bit               m_used[BUFS];
  int               m_free;
  bit               m_err;
  logic             exp_gv;
  logic [1:0]       exp_gn;
  logic [WBUFS-1:0] exp_idx[3];
  logic [BUFS-1:0]  exp_q[$];

  function automatic logic [BUFS-1:0] model_occ();
    logic [BUFS-1:0] v;
    for (int i = 0; i < BUFS; i++) v[i] = m_used[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BUFS; i++) m_used[i] = 1'b0;
    m_free = BUFS;
    m_err  = 1'b0;
    exp_gv = 1'b0;
    exp_gn = 2'd0;
    for (int k = 0; k < 3; k++) exp_idx[k] = '0;
    exp_q.delete();
  endtask

  // One cycle of pool behaviour, evaluated on the state before the edge.
  task automatic model_step(input logic v, input logic [1:0] n, input logic rv, input logic [WBUFS-1:0] ri);
    int picks[$];
    bit acc;
    bit rok;
    acc = v && (n != 2'd0) && (int'(n) <= m_free);
    rok = 1'b0;
    if (rv && ri < BUFS) rok = m_used[ri[2:0]];
    if (acc)
      for (int i = 0; i < BUFS; i++)
        if (!m_used[i] && picks.size() < int'(n)) picks.push_back(i);
    foreach (picks[k]) m_used[picks[k]] = 1'b1;
    if (rok) m_used[ri[2:0]] = 1'b0;
    m_free = m_free - (acc ? int'(n) : 0) + (rok ? 1 : 0);
    if (rv && !rok) m_err = 1'b1;
    exp_gv = acc;
    if (acc) begin
      exp_gn = n;
      for (int k = 0; k < int'(n); k++) exp_idx[k] = WBUFS'(picks[k]);
    end
    exp_q.push_back(model_occ());
  endtask

  // ---- driver tasks ----
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; alloc_vld = 1'b0; alloc_num = 2'd0; rel_vld = 1'b0; rel_idx = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic v, input logic [1:0] n, input logic rv, input logic [WBUFS-1:0] ri);
    @(negedge clk);
    alloc_vld = v; alloc_num = n; rel_vld = rv; rel_idx = ri;
    model_step(v, n, rv, ri);
    @(posedge clk); #1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    do_reset();
    n_vec++; if (occupied !== 8'h00) begin n_err++; $display("FAIL reset occupied got %h exp 00", occupied); end
    n_vec++; if (free_count !== 6'd8) begin n_err++; $display("FAIL reset free_count got %0d exp 8", free_count); end
    n_vec++; if (low_free !== 1'b0) begin n_err++; $display("FAIL reset low_free got %b exp 0", low_free); end
    n_vec++; if (gnt_vld !== 1'b0 || gnt_num !== 2'd0) begin n_err++; $display("FAIL reset gnt got vld=%b num=%0d exp 0/0", gnt_vld, gnt_num); end
    n_vec++; if ({gnt_idx0, gnt_idx1, gnt_idx2} !== 18'd0) begin n_err++; $display("FAIL reset gnt_idx got %0d %0d %0d exp 0 0 0", gnt_idx0, gnt_idx1, gnt_idx2); end
    n_vec++; if (err_rel !== 1'b0) begin n_err++; $display("FAIL reset err_rel got %b exp 0", err_rel); end
  endtask

  task automatic test_single_alloc();
    do_reset();
    step(1'b1, 2'd1, 1'b0, '0);
    n_vec++; if (gnt_vld !== 1'b1 || gnt_num !== 2'd1 || gnt_idx0 !== 6'd0) begin n_err++; $display("FAIL single grant got vld=%b num=%0d idx0=%0d exp 1/1/0", gnt_vld, gnt_num, gnt_idx0); end
    n_vec++; if (occupied !== 8'h01 || free_count !== 6'd7) begin n_err++; $display("FAIL single state got occ=%h free=%0d exp 01/7", occupied, free_count); end
    step(1'b0, 2'd0, 1'b0, '0);
    n_vec++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL single pulse got gnt_vld=%b exp 0", gnt_vld); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 2'd3, 1'b0, '0);
    n_vec++; if (gnt_vld !== 1'b1 || {gnt_idx0, gnt_idx1, gnt_idx2} !== {6'd0, 6'd1, 6'd2}) begin n_err++; $display("FAIL b2b first got vld=%b idx=%0d,%0d,%0d exp 1 0,1,2", gnt_vld, gnt_idx0, gnt_idx1, gnt_idx2); end
    step(1'b1, 2'd3, 1'b0, '0);
    n_vec++; if (gnt_vld !== 1'b1 || {gnt_idx0, gnt_idx1, gnt_idx2} !== {6'd3, 6'd4, 6'd5}) begin n_err++; $display("FAIL b2b second got vld=%b idx=%0d,%0d,%0d exp 1 3,4,5", gnt_vld, gnt_idx0, gnt_idx1, gnt_idx2); end
    n_vec++; if (occupied !== 8'h3F || free_count !== 6'd2 || low_free !== 1'b1) begin n_err++; $display("FAIL b2b state got occ=%h free=%0d low=%b exp 3f/2/1", occupied, free_count, low_free); end
  endtask

  task automatic test_full_wait();
    // continues from occupied = 3f
    step(1'b1, 2'd3, 1'b0, '0);
    n_vec++; if (alloc_rdy !== 1'b0 || gnt_vld !== 1'b0 || occupied !== 8'h3F) begin n_err++; $display("FAIL wait3 got rdy=%b gnt=%b occ=%h exp 0/0/3f", alloc_rdy, gnt_vld, occupied); end
    step(1'b1, 2'd3, 1'b1, 6'd4);
    n_vec++; if (gnt_vld !== 1'b0 || occupied !== 8'h2F || free_count !== 6'd3) begin n_err++; $display("FAIL release4 got gnt=%b occ=%h free=%0d exp 0/2f/3", gnt_vld, occupied, free_count); end
    n_vec++; if (alloc_rdy !== 1'b1 || low_free !== 1'b0) begin n_err++; $display("FAIL release4 rdy got rdy=%b low=%b exp 1/0", alloc_rdy, low_free); end
    step(1'b1, 2'd3, 1'b0, '0);
    n_vec++; if (gnt_vld !== 1'b1 || {gnt_idx0, gnt_idx1, gnt_idx2} !== {6'd4, 6'd6, 6'd7}) begin n_err++; $display("FAIL refill got vld=%b idx=%0d,%0d,%0d exp 1 4,6,7", gnt_vld, gnt_idx0, gnt_idx1, gnt_idx2); end
    n_vec++; if (occupied !== 8'hFF || free_count !== 6'd0 || low_free !== 1'b1) begin n_err++; $display("FAIL full state got occ=%h free=%0d low=%b exp ff/0/1", occupied, free_count, low_free); end
    @(negedge clk); alloc_num = 2'd1; #1;
    n_vec++; if (alloc_rdy !== 1'b0) begin n_err++; $display("FAIL full rdy got %b exp 0", alloc_rdy); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 2'd3, 1'b0, '0);
    step(1'b1, 2'd1, 1'b0, '0);
    n_vec++; if (occupied !== 8'h0F || free_count !== 6'd4) begin n_err++; $display("FAIL sim setup got occ=%h free=%0d exp 0f/4", occupied, free_count); end
    step(1'b1, 2'd2, 1'b1, 6'd1);
    n_vec++; if (gnt_vld !== 1'b1 || gnt_num !== 2'd2 || gnt_idx0 !== 6'd4 || gnt_idx1 !== 6'd5) begin n_err++; $display("FAIL sim grant got vld=%b num=%0d idx=%0d,%0d exp 1/2 4,5", gnt_vld, gnt_num, gnt_idx0, gnt_idx1); end
    n_vec++; if (gnt_idx2 !== 6'd2) begin n_err++; $display("FAIL sim idx2 hold got %0d exp 2", gnt_idx2); end
    n_vec++; if (occupied !== 8'h3D || free_count !== 6'd3) begin n_err++; $display("FAIL sim state got occ=%h free=%0d exp 3d/3", occupied, free_count); end
  endtask

  task automatic test_rel_errors();
    // continues from occupied = 3d
    step(1'b0, 2'd0, 1'b1, 6'd6);
    n_vec++; if (occupied !== 8'h3D || free_count !== 6'd3 || err_rel !== 1'b1) begin n_err++; $display("FAIL rel6 got occ=%h free=%0d err=%b exp 3d/3/1", occupied, free_count, err_rel); end
    step(1'b0, 2'd0, 1'b1, 6'd9);
    n_vec++; if (occupied !== 8'h3D || free_count !== 6'd3 || err_rel !== 1'b1) begin n_err++; $display("FAIL rel9 got occ=%h free=%0d err=%b exp 3d/3/1", occupied, free_count, err_rel); end
    step(1'b0, 2'd0, 1'b1, 6'd0);
    n_vec++; if (occupied !== 8'h3C || free_count !== 6'd4 || err_rel !== 1'b1) begin n_err++; $display("FAIL rel0 sticky got occ=%h free=%0d err=%b exp 3c/4/1", occupied, free_count, err_rel); end
    do_reset();
    n_vec++; if (err_rel !== 1'b0) begin n_err++; $display("FAIL err clear got %b exp 0", err_rel); end
    step(1'b0, 2'd0, 1'b1, 6'd0);
    n_vec++; if (err_rel !== 1'b1 || free_count !== 6'd8 || occupied !== 8'h00) begin n_err++; $display("FAIL empty rel got err=%b free=%0d occ=%h exp 1/8/00", err_rel, free_count, occupied); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 2'd2, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1; alloc_vld = 1'b1; alloc_num = 2'd2;
    @(posedge clk); #1;
    n_vec++; if (gnt_vld !== 1'b0 || occupied !== 8'h00 || free_count !== 6'd8) begin n_err++; $display("FAIL mid reset got gnt=%b occ=%h free=%0d exp 0/00/8", gnt_vld, occupied, free_count); end
    rst = 1'b0;
    model_reset();
    step(1'b0, 2'd0, 1'b0, '0);
    n_vec++; if (gnt_vld !== 1'b0 || occupied !== 8'h00) begin n_err++; $display("FAIL post reset got gnt=%b occ=%h exp 0/00", gnt_vld, occupied); end
  endtask

  task automatic test_random_soak();
    logic             v, rv;
    logic [1:0]       n;
    logic [WBUFS-1:0] ri;
    logic [BUFS-1:0]  eo;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      n  = 2'($urandom_range(0, 3));
      rv = ($urandom_range(0, 2) != 0);
      ri = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(8, 15)) : 6'($urandom_range(0, 7));
      @(negedge clk);
      alloc_vld = v; alloc_num = n; rel_vld = rv; rel_idx = ri;
      #1;
      n_vec++; if (alloc_rdy !== (int'(n) <= m_free)) begin n_err++; $display("FAIL soak rdy c=%0d got %b free_model=%0d num=%0d", c, alloc_rdy, m_free, n); end
      model_step(v, n, rv, ri);
      @(posedge clk); #1;
      eo = exp_q.pop_front();
      n_vec++; if (occupied !== eo) begin n_err++; $display("FAIL soak occupied c=%0d got %h exp %h", c, occupied, eo); end
      n_vec++; if (free_count !== WBUFS'(m_free)) begin n_err++; $display("FAIL soak free_count c=%0d got %0d exp %0d", c, free_count, m_free); end
      n_vec++; if (free_count !== WBUFS'(BUFS - $countones(occupied))) begin n_err++; $display("FAIL soak popcount c=%0d got free=%0d occ=%h", c, free_count, occupied); end
      n_vec++; if (low_free !== (m_free <= 2)) begin n_err++; $display("FAIL soak low_free c=%0d got %b free_model=%0d", c, low_free, m_free); end
      n_vec++; if (err_rel !== m_err) begin n_err++; $display("FAIL soak err_rel c=%0d got %b exp %b", c, err_rel, m_err); end
      n_vec++; if (gnt_vld !== exp_gv || gnt_num !== exp_gn) begin n_err++; $display("FAIL soak gnt c=%0d got vld=%b num=%0d exp %b/%0d", c, gnt_vld, gnt_num, exp_gv, exp_gn); end
      n_vec++; if (gnt_idx0 !== exp_idx[0] || gnt_idx1 !== exp_idx[1] || gnt_idx2 !== exp_idx[2]) begin n_err++; $display("FAIL soak idx c=%0d got %0d,%0d,%0d exp %0d,%0d,%0d", c, gnt_idx0, gnt_idx1, gnt_idx2, exp_idx[0], exp_idx[1], exp_idx[2]); end
    end
  endtask

  // ---- sequence and report ----
  initial begin
    model_reset();
    test_reset();
    test_single_alloc();
    test_back_to_back();
    test_full_wait();
    test_simultaneous();
    test_rel_errors();
    test_reset_mid();
    test_random_soak();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
